// File: rtl/mux_2to1_core.sv
// mux_2to1_core: combinational WIDTH-bit 2-to-1 select, sel=0 -> a, sel=1 -> b
module mux_2to1_core #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y_comb
);
  assign y_comb = sel ? b : a;
endmodule

// File: rtl/mux_2to1.sv
// mux_2to1: 2-to-1 data selector with optional registered output and y_valid
module mux_2to1 #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);
  logic [WIDTH-1:0] y_comb;
  mux_2to1_core #(.WIDTH(WIDTH)) u_core (
    .a(a),
    .b(b),
    .sel(sel),
    .y_comb(y_comb)
  );
  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y       <= '0;
        y_valid <= 1'b0;
      end else begin
        y       <= y_comb;
        y_valid <= 1'b1;
      end
    end
  end else begin : g_comb
    // clk only matters for the registered variant
    logic unused_clk;
    assign unused_clk = clk;
    assign y          = y_comb;
    assign y_valid    = rst_n;
  end
endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: directed checks of registered (1-bit, 8-bit) and combinational variants
module tb_mux_2to1;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a1, b1, sel1, y1, v1;
  logic [7:0] a8, b8, y8;
  logic       sel8, v8;
  logic       ac, bc, selc, yc, vc;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  mux_2to1 #(.WIDTH(1), .REG_OUT(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .y(y1), .y_valid(v1)
  );
  mux_2to1 #(.WIDTH(8), .REG_OUT(1)) u_r8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .y(y8), .y_valid(v8)
  );
  mux_2to1 #(.WIDTH(1), .REG_OUT(0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .a(ac), .b(bc), .sel(selc), .y(yc), .y_valid(vc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {a, b, sel, expected y}
  logic [3:0] tt [6] = '{4'b0000, 4'b1010, 4'b0100, 4'b1111, 4'b1001, 4'b0111};
  logic [7:0] wide_exp [4] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};

  initial begin
    a1 = 1'b1; b1 = 1'b1; sel1 = 1'b1;
    a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b0;
    ac = 1'b1; bc = 1'b0; selc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_y1", y1, 0);
      check("rst_v1", v1, 0);
      check("rst_y8", y8, 0);
      check("rst_vc", vc, 0);
    end
    rst_n = 1'b1;
    #1;
    check("pre_edge_y1", y1, 0);
    tick();
    check("rel_y1", y1, 1);
    check("rel_v1", v1, 1);
    check("rel_y8", y8, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      {a1, b1, sel1} = tt[i][3:1];
      tick();
      check($sformatf("tt%0d", i), y1, tt[i][0]);
    end
    a1 = 1'b0; b1 = 1'b1; sel1 = 1'b0;
    tick();
    check("lat_base", y1, 0);
    sel1 = 1'b1;
    #2 check("lat_mid_a", y1, 0);
    #2 check("lat_mid_b", y1, 0);
    tick();
    check("lat_edge", y1, 1);
    for (int i = 0; i < 4; i++) begin
      sel8 = i[0];
      tick();
      check($sformatf("wide%0d", i), y8, wide_exp[i]);
    end
    check("wide_valid", v8, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_y8", y8, 0);
    check("async_v8", v8, 0);
    check("async_y1", y1, 0);
    check("async_vc", vc, 0);
    #1 rst_n = 1'b1;
    #1;
    check("rerel_hold_y8", y8, 0);
    check("rerel_hold_v8", v8, 0);
    tick();
    check("rerel_y8", y8, 8'h3C);
    check("rerel_v8", v8, 1);
    ac = 1'b1; bc = 1'b0; selc = 1'b0;
    #1 check("comb_sel0", yc, 1);
    selc = 1'b1;
    #1 check("comb_sel1", yc, 0);
    check("comb_valid", vc, 1);
    ac = 1'b1; bc = 1'b1; selc = 1'b0;
    #1 check("comb_eq", yc, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_2to1.md
Name: mux_2to1

Overview:
- Parameterised 2-to-1 data selector with a registered output.
- Picks operand `a` or `b` per `sel` and presents the result on `y` one clock later.
- Used as a leaf datapath primitive wherever two same-width sources feed one sink.
- Sub-module-free except for an optional combinational core; no handshake with upstream.

Parameters:
- WIDTH, 1, bit width of a, b and y (legal range 1..1024).
- REG_OUT, 1, 1 = output registered (1-cycle latency); 0 = purely combinational path, clk/rst_n unused for y.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand selected when sel=0
- b  input  WIDTH  operand selected when sel=1
- sel  input  1  select: 0 -> a, 1 -> b
- y  output  WIDTH  selected operand
- y_valid  output  1  high once y holds a value captured after reset release

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Select function: next_y = sel ? b : a, bitwise across all WIDTH bits. There is no arithmetic and no width change.
- REG_OUT=1:
  - y updates on every rising clk edge from the a/b/sel values sampled at that edge.
  - Latency is exactly 1 cycle and throughput is 1 per cycle. There is no enable, so every edge loads.
- REG_OUT=0:
  - y = sel ? b : a, combinationally, with zero latency.
  - y_valid is tied to rst_n, i.e. high whenever out of reset.
- Reset, when rst_n=0:
  - y = 0 (all bits) and y_valid = 0, both immediately and independent of clk.
  - This applies mid-operation too: an asserted rst_n forces the outputs low within the same cycle.
- Reset release:
  - The first rising clk edge with rst_n=1 loads y and sets y_valid=1.
  - y_valid stays 1 until the next reset.
- Simultaneous change of sel and data before an edge: the edge captures the values present at that edge; no ordering dependency.
- sel toggling every cycle: y follows with 1-cycle delay; no glitch on registered y.
- a == b: y = a regardless of sel.
- X/Z on sel: no requirement on y beyond simulator semantics. Synthesis treats sel as a strict 2-state select.
- No internal state besides the y and y_valid registers. There is no state machine.

Decomposition:
- No shared package needed. WIDTH is local, and there are no typedefs or constants used elsewhere.
- One natural sub-module: mux_2to1_core.
  - Purely combinational, parameter WIDTH, ports a, b, sel, y_comb.
  - Instantiated by mux_2to1.
  - The REG_OUT generate branch either registers y_comb or passes it through.

Test Plan:
- Reset: hold rst_n=0 with a=1, b=1, sel=1 and clk running -> y=0 and y_valid=0 throughout. Release rst_n -> after the first edge, y=1 and y_valid=1.
- Truth table (WIDTH=1, REG_OUT=1): apply each of the following, sampled one edge later.
  - a=0, b=0, sel=0 -> y=0
  - a=1, b=0, sel=1 -> y=0
  - a=0, b=1, sel=0 -> y=0
  - a=1, b=1, sel=1 -> y=1
  - a=1, b=0, sel=0 -> y=1
  - a=0, b=1, sel=1 -> y=1
- Latency: change sel 0->1 with a=0, b=1 just after an edge -> y stays 0 until the next edge, then 1. Verify y never changes between edges.
- Wide data (WIDTH=8): a=8'hA5, b=8'h3C, alternating sel 0,1,0,1 on consecutive cycles -> y sequence is A5, 3C, A5, 3C, one cycle delayed.
- Async reset mid-stream: drop rst_n between edges while y=8'h3C -> y=0 and y_valid=0 immediately, without waiting for an edge. Re-release -> normal operation resumes on the next edge.
- Combinational mode (REG_OUT=0): a=1, b=0, sel toggled 0->1 -> y changes 1->0 in the same timestep; y_valid equals rst_n.
